pwm_button_conditioner: RTL and testbench

- Upstream input stage for pwm_signal_generator.
- Takes the raw, asynchronous up/down push-button lines from the input pins.
- Synchronises and debounces each line.
- Turns each debounced press into single-cycle step pulses on xu/xd, with hold-to-auto-repeat, so the PWM generator receives clean one-cycle increment/decrement requests.

---
 rtl/pwm_button_conditioner.sv | 191 +++++++++++++++++++
 tb/tb_pwm_button_conditioner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pwm_button_conditioner.sv
// Push-button front end for the PWM generator: synchronises, debounces and
// converts the up/down buttons into one-cycle step pulses with auto-repeat.

module pwm_button_channel #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 256,
    parameter int REPEAT_PERIOD   = 64,
    parameter int CNT_W           = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn,
    output logic db_q,
    output logic db_d,
    output logic pulse_d
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_e;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] dbc_q, dbc_d;
    logic [CNT_W-1:0] rc_q, rc_d;
    state_e           state_q, state_d;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        db_d    = db_q;
        dbc_d   = dbc_q;
        if (sync2_q == db_q) begin
            dbc_d = '0;
        end else if (dbc_q == DB_LAST) begin
            db_d  = sync2_q;
            dbc_d = '0;
        end else begin
            dbc_d = dbc_q + 1'b1;
        end
    end

    // The FSM looks at the level being accepted on this edge, so the first
    // pulse lines up with the debounced rise.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        pulse_d = 1'b0;
        if (!ena || !db_d) begin
            state_d = ST_IDLE;
            rc_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!db_q) begin
                        pulse_d = 1'b1;
                        rc_d    = '0;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rc_q == RD_LAST) begin
                        pulse_d = 1'b1;
                        rc_d    = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (rc_q == RP_LAST) begin
                        pulse_d = 1'b1;
                        rc_d    = '0;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rc_d    = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            dbc_q   <= '0;
            rc_q    <= '0;
            state_q <= ST_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            dbc_q   <= dbc_d;
            rc_q    <= rc_d;
            state_q <= state_d;
        end
    end

endmodule

module pwm_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 256,
    parameter int REPEAT_PERIOD   = 64,
    parameter int CNT_W           = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn_up,
    input  logic btn_dn,
    output logic xu,
    output logic xd,
    output logic up_db,
    output logic dn_db
);

    logic up_db_d, dn_db_d;
    logic up_pulse_d, dn_pulse_d;
    logic xu_q, xu_d;
    logic xd_q, xd_d;
    logic conflict_d;

    pwm_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_W           (CNT_W)
    ) u_up (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .btn     (btn_up),
        .db_q    (up_db),
        .db_d    (up_db_d),
        .pulse_d (up_pulse_d)
    );

    pwm_button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_W           (CNT_W)
    ) u_dn (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .btn     (btn_dn),
        .db_q    (dn_db),
        .db_d    (dn_db_d),
        .pulse_d (dn_pulse_d)
    );

    // Both buttons held means an ambiguous request: suppress both directions
    // while the channel FSMs keep their timing.
    always_comb begin
        conflict_d = up_db_d & dn_db_d;
        xu_d       = up_pulse_d & ~conflict_d;
        xd_d       = dn_pulse_d & ~conflict_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xu_q <= 1'b0;
            xd_q <= 1'b0;
        end else begin
            xu_q <= xu_d;
            xd_q <= xd_d;
        end
    end

    assign xu = xu_q;
    assign xd = xd_q;

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// Directed bench for pwm_button_conditioner with short debounce/repeat times;
// edge numbers count rising edges after the stimulus is applied.

module tb_pwm_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic btn_up;
    logic btn_dn;
    logic xu;
    logic xd;
    logic up_db;
    logic dn_db;

    int n_checks = 0;
    int n_errors = 0;

    pwm_button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .btn_up (btn_up),
        .btn_dn (btn_dn),
        .xu     (xu),
        .xd     (xd),
        .up_db  (up_db),
        .dn_db  (dn_db)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ena    = 1'b1;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

        // Reset with both buttons pressed
        rst    = 1'b1;
        ena    = 1'b1;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_xu", xu, 1'b0);
            check("rst_xd", xd, 1'b0);
            check("rst_up_db", up_db, 1'b0);
            check("rst_dn_db", dn_db, 1'b0);
        end
        rst = 1'b0;
        step();
        check("post_rst_xu", xu, 1'b0);
        check("post_rst_xd", xd, 1'b0);
        check("post_rst_up_db", up_db, 1'b0);
        check("post_rst_dn_db", dn_db, 1'b0);

        // Single press held 7 cycles
        do_reset();
        btn_up = 1'b1;
        for (int e = 0; e < 16; e++) begin
            if (e == 7) btn_up = 1'b0;
            step();
            check("single_xu", xu, e == 5);
            check("single_up_db", up_db, e >= 5 && e < 12);
            check("single_xd", xd, 1'b0);
        end

        // Hold down button: first pulse, delay, then periodic repeats
        do_reset();
        btn_dn = 1'b1;
        for (int e = 0; e < 32; e++) begin
            step();
            check("repeat_xd", xd, e == 5 || (e >= 13 && (e - 13) % 4 == 0));
            check("repeat_xu", xu, 1'b0);
            check("repeat_dn_db", dn_db, e >= 5);
        end

        // Bounce runs of 3 rejected, then a steady press accepted
        do_reset();
        for (int e = 0; e < 21; e++) begin
            btn_up = (e < 8) ? pat[e][0] : 1'b1;
            step();
            check("bounce_xu", xu, e == 13);
            check("bounce_up_db", up_db, e >= 13);
        end

        // Simultaneous presses held through the repeat window
        do_reset();
        btn_up = 1'b1;
        btn_dn = 1'b1;
        for (int e = 0; e < 20; e++) begin
            step();
            check("conflict_xu", xu, 1'b0);
            check("conflict_xd", xd, 1'b0);
            check("conflict_up_db", up_db, e >= 5);
            check("conflict_dn_db", dn_db, e >= 5);
        end

        // Press while disabled, enable while held, then release and re-press
        do_reset();
        ena    = 1'b0;
        btn_up = 1'b1;
        for (int e = 0; e < 36; e++) begin
            if (e == 8) ena = 1'b1;
            btn_up = (e < 20) || (e >= 27);
            step();
            check("ena_xu", xu, e == 32);
            check("ena_up_db", up_db, (e >= 5 && e < 25) || e >= 32);
        end

        // Reset one cycle before a due repeat pulse
        do_reset();
        btn_up = 1'b1;
        for (int e = 0; e < 25; e++) begin
            rst = (e == 16);
            step();
            check("midrst_xu", xu, e == 5 || e == 13 || e == 22);
            check("midrst_up_db", up_db, (e >= 5 && e < 16) || e >= 22);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
